// File: rtl/bp_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// bp_cfg_sequencer
//   Boot-time configuration sequencer. A pass runs through these phases:
//     1. freeze every core tile
//     2. program CORE_ID, CCE_MODE and NPC for each tile in turn
//     3. unfreeze every tile
//   Writes go out one at a time over a registered valid/ready interface.
//
// Optional feature (macro BP_CFG_SEQUENCER_TIMEOUT_EN):
//   Any single write stalled for timeout_p cycles aborts the pass into
//   ERROR. Without the macro the sequencer waits indefinitely and error_o
//   is tied low.
//
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   start_i             begin a pass (accepted in IDLE/DONE/ERROR only)
//   cce_mode_i          CCE mode to program, captured on the start cycle
//   boot_pc_i           boot PC to program, captured on the start cycle
//   cfg_v_o/cfg_ready_i write handshake
//   cfg_core_o          destination tile index
//   cfg_addr_o          config register address
//   cfg_data_o          config write data
//   busy_o              pass in progress
//   done_o              last pass completed; held until the next start
//   error_o             write timeout (optional feature)
// ---------------------------------------------------------------------------
module bp_cfg_sequencer #(
  parameter int num_core_p       = 1,
  parameter int vaddr_width_p    = 39,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int timeout_p        = 1024,
  localparam int core_width_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        cce_mode_i,
  input  logic [vaddr_width_p-1:0]    boot_pc_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_width_lp-1:0]    cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o
);

  // Invalid parameterisations stop elaboration.
  if ((num_core_p < 1) || (timeout_p < 1) || (cfg_data_width_p < vaddr_width_p)) begin : g_bad_params
    $error("bp_cfg_sequencer: illegal parameter combination");
  end

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FREEZE    = 3'd1;
  localparam logic [2:0] S_PROG_ID   = 3'd2;
  localparam logic [2:0] S_PROG_MODE = 3'd3;
  localparam logic [2:0] S_PROG_NPC  = 3'd4;
  localparam logic [2:0] S_UNFREEZE  = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
`ifdef BP_CFG_SEQUENCER_TIMEOUT_EN
  localparam logic [2:0] S_ERROR     = 3'd7;
`endif

  localparam logic [cfg_addr_width_p-1:0] ADDR_FREEZE   = cfg_addr_width_p'(16'h0000);
  localparam logic [cfg_addr_width_p-1:0] ADDR_CORE_ID  = cfg_addr_width_p'(16'h0004);
  localparam logic [cfg_addr_width_p-1:0] ADDR_CCE_MODE = cfg_addr_width_p'(16'h0008);
  localparam logic [cfg_addr_width_p-1:0] ADDR_NPC      = cfg_addr_width_p'(16'h000C);

  localparam logic [core_width_lp-1:0] CORE_LAST = core_width_lp'(num_core_p - 1);

  logic [2:0]                  r_state;
  logic [core_width_lp-1:0]    r_core;
  logic                        r_mode;
  logic [vaddr_width_p-1:0]    r_pc;
  logic                        r_v;
  logic [cfg_addr_width_p-1:0] r_addr;
  logic [cfg_data_width_p-1:0] r_data;
  logic                        r_done;

  logic [2:0]                  w_state_n;
  logic [core_width_lp-1:0]    w_core_n;
  logic                        w_mode_n;
  logic [vaddr_width_p-1:0]    w_pc_n;
  logic                        w_v_n;
  logic [cfg_addr_width_p-1:0] w_addr_n;
  logic [cfg_data_width_p-1:0] w_data_n;
  logic                        w_hs;
  logic                        w_last;
  logic                        w_can_start;
  logic [core_width_lp-1:0]    w_core_inc;

  assign w_hs       = r_v & cfg_ready_i;
  assign w_last     = (r_core == CORE_LAST);
  // The counter restarts at 0 on every phase change, so it never reaches num_core_p.
  assign w_core_inc = w_last ? '0 : (r_core + core_width_lp'(1));

`ifdef BP_CFG_SEQUENCER_TIMEOUT_EN
  localparam int wait_width_lp = $clog2(timeout_p + 1);
  localparam logic [wait_width_lp-1:0] WAIT_LAST = wait_width_lp'(timeout_p - 1);

  logic [wait_width_lp-1:0] r_wait;
  logic [wait_width_lp-1:0] w_wait_n;
  logic                     w_timeout;
  logic                     r_err;

  assign w_can_start = (r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR);

  // Stall counter: cleared outside write states and on each handshake.
  always_comb begin
    w_wait_n  = r_wait;
    w_timeout = 1'b0;
    if (!r_v || w_hs) begin
      w_wait_n = '0;
    end else begin
      w_wait_n  = r_wait + wait_width_lp'(1);
      w_timeout = (r_wait == WAIT_LAST);
    end
  end

  // Stall counter and error flag registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wait <= w_wait_n;
      r_err  <= (w_state_n == S_ERROR);
    end
  end

  assign error_o = r_err;
`else
  assign w_can_start = (r_state == S_IDLE) | (r_state == S_DONE);
  assign error_o     = 1'b0;
`endif

  // Next-state logic: phase sequencing and core stepping on handshakes.
  always_comb begin
    w_state_n = r_state;
    w_core_n  = r_core;
    w_mode_n  = r_mode;
    w_pc_n    = r_pc;
    if (w_can_start && start_i) begin
      w_state_n = S_FREEZE;
      w_core_n  = '0;
      w_mode_n  = cce_mode_i;
      w_pc_n    = boot_pc_i;
    end else begin
      case (r_state)
        S_FREEZE: begin
          if (w_hs) begin
            w_core_n  = w_core_inc;
            w_state_n = w_last ? S_PROG_ID : S_FREEZE;
          end else begin
            w_state_n = r_state;
          end
        end
        S_PROG_ID: begin
          if (w_hs) begin
            w_state_n = S_PROG_MODE;
          end else begin
            w_state_n = r_state;
          end
        end
        S_PROG_MODE: begin
          if (w_hs) begin
            w_state_n = S_PROG_NPC;
          end else begin
            w_state_n = r_state;
          end
        end
        S_PROG_NPC: begin
          if (w_hs) begin
            w_core_n  = w_core_inc;
            w_state_n = w_last ? S_UNFREEZE : S_PROG_ID;
          end else begin
            w_state_n = r_state;
          end
        end
        S_UNFREEZE: begin
          if (w_hs) begin
            w_core_n  = w_core_inc;
            w_state_n = w_last ? S_DONE : S_UNFREEZE;
          end else begin
            w_state_n = r_state;
          end
        end
        default: begin
          w_state_n = r_state;
        end
      endcase
`ifdef BP_CFG_SEQUENCER_TIMEOUT_EN
      if (w_timeout) begin
        w_state_n = S_ERROR;
        w_core_n  = '0;
      end else begin
        w_core_n  = w_core_n;
      end
`endif
    end
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    w_v_n    = 1'b0;
    w_addr_n = '0;
    w_data_n = '0;
    case (w_state_n)
      S_FREEZE: begin
        w_v_n    = 1'b1;
        w_addr_n = ADDR_FREEZE;
        w_data_n = cfg_data_width_p'(1'b1);
      end
      S_PROG_ID: begin
        w_v_n    = 1'b1;
        w_addr_n = ADDR_CORE_ID;
        w_data_n = cfg_data_width_p'(w_core_n);
      end
      S_PROG_MODE: begin
        w_v_n    = 1'b1;
        w_addr_n = ADDR_CCE_MODE;
        w_data_n = cfg_data_width_p'(w_mode_n);
      end
      S_PROG_NPC: begin
        w_v_n    = 1'b1;
        w_addr_n = ADDR_NPC;
        w_data_n = cfg_data_width_p'(w_pc_n);
      end
      S_UNFREEZE: begin
        w_v_n    = 1'b1;
        w_addr_n = ADDR_FREEZE;
        w_data_n = '0;
      end
      default: begin
        w_v_n    = 1'b0;
        w_addr_n = '0;
        w_data_n = '0;
      end
    endcase
  end

  // State, captured pass arguments and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_core  <= '0;
      r_mode  <= 1'b0;
      r_pc    <= '0;
      r_v     <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_core  <= w_core_n;
      r_mode  <= w_mode_n;
      r_pc    <= w_pc_n;
      r_v     <= w_v_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
      r_done  <= (w_state_n == S_DONE);
    end
  end

  assign cfg_v_o    = r_v;
  assign busy_o     = r_v;  // a pass is in progress exactly while a write is offered
  assign cfg_core_o = r_core;
  assign cfg_addr_o = r_addr;
  assign cfg_data_o = r_data;
  assign done_o     = r_done;

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
module tb_bp_cfg_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: two cores, short timeout
  logic        a_start, a_mode, a_ready, a_v, a_busy, a_done, a_err;
  logic [38:0] a_pc;
  logic [0:0]  a_core;
  logic [15:0] a_addr;
  logic [63:0] a_data;

  // DUT B: three cores
  logic        b_start, b_mode, b_ready, b_v, b_busy, b_done, b_err;
  logic [38:0] b_pc;
  logic [1:0]  b_core;
  logic [15:0] b_addr;
  logic [63:0] b_data;

  bp_cfg_sequencer #(.num_core_p(2), .timeout_p(8)) dut_a (
    .clk_i(clk), .reset_i(rst), .start_i(a_start), .cce_mode_i(a_mode),
    .boot_pc_i(a_pc), .cfg_v_o(a_v), .cfg_ready_i(a_ready), .cfg_core_o(a_core),
    .cfg_addr_o(a_addr), .cfg_data_o(a_data), .busy_o(a_busy), .done_o(a_done),
    .error_o(a_err));

  bp_cfg_sequencer #(.num_core_p(3)) dut_b (
    .clk_i(clk), .reset_i(rst), .start_i(b_start), .cce_mode_i(b_mode),
    .boot_pc_i(b_pc), .cfg_v_o(b_v), .cfg_ready_i(b_ready), .cfg_core_o(b_core),
    .cfg_addr_o(b_addr), .cfg_data_o(b_data), .busy_o(b_busy), .done_o(b_done),
    .error_o(b_err));

  // write logs captured from the handshakes
  int          a_lc[$], a_lt[$], b_lc[$];
  logic [15:0] a_la[$], b_la[$];
  logic [63:0] a_ld[$], b_ld[$];
  // expected write sequence
  int          e_core[$];
  logic [15:0] e_addr[$];
  logic [63:0] e_data[$];

  always @(negedge clk) begin
    if (a_v && a_ready) begin
      a_lc.push_back(int'(a_core)); a_la.push_back(a_addr); a_ld.push_back(a_data); a_lt.push_back(cyc);
    end
    if (b_v && b_ready) begin
      b_lc.push_back(int'(b_core)); b_la.push_back(b_addr); b_ld.push_back(b_data);
    end
  end

  task automatic clear_logs();
    a_lc.delete(); a_la.delete(); a_ld.delete(); a_lt.delete();
    b_lc.delete(); b_la.delete(); b_ld.delete();
    e_core.delete(); e_addr.delete(); e_data.delete();
  endtask

  // Expected pass: freeze all, then ID/MODE/NPC per core, then unfreeze all.
  task automatic load_exp(input int n, input logic mode, input logic [63:0] pc);
    for (int c = 0; c < n; c++) begin
      e_core.push_back(c); e_addr.push_back(16'h0000); e_data.push_back(64'd1);
    end
    for (int c = 0; c < n; c++) begin
      e_core.push_back(c); e_addr.push_back(16'h0004); e_data.push_back(64'(c));
      e_core.push_back(c); e_addr.push_back(16'h0008); e_data.push_back({63'd0, mode});
      e_core.push_back(c); e_addr.push_back(16'h000C); e_data.push_back(pc);
    end
    for (int c = 0; c < n; c++) begin
      e_core.push_back(c); e_addr.push_back(16'h0000); e_data.push_back(64'd0);
    end
  endtask

  task automatic start_pass_a(input logic mode, input logic [38:0] pc);
    @(posedge clk); #1;
    a_start = 1'b1; a_mode = mode; a_pc = pc;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_start = 1'b0; a_mode = 1'b0; a_pc = '0; a_ready = 1'b0;
    b_start = 1'b0; b_mode = 1'b0; b_pc = '0; b_ready = 1'b0;
    #1;
    n_vec++;
    if ({a_v, a_busy, a_done, a_err, a_core, a_addr, a_data} !== '0) begin
      n_err++; $display("FAIL reset_a: outputs=%h required 0", {a_v, a_busy, a_done, a_err, a_core, a_addr, a_data});
    end
    n_vec++;
    if ({b_v, b_busy, b_done, b_err, b_core, b_addr, b_data} !== '0) begin
      n_err++; $display("FAIL reset_b: outputs=%h required 0", {b_v, b_busy, b_done, b_err, b_core, b_addr, b_data});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({a_v, a_busy, a_done} !== 3'b000) begin
      n_err++; $display("FAIL idle_a: v/busy/done=%b required 000", {a_v, a_busy, a_done});
    end
  endtask

  task automatic test_basic();
    bit seen_done = 1'b0;
    int done_cyc = 0;
    clear_logs();
    load_exp(2, 1'b1, 64'h8000_0000);
    a_ready = 1'b1;
    start_pass_a(1'b1, 39'h80000000);
    for (int t = 0; t < 50 && !seen_done; t++) begin
      @(negedge clk);
      if (a_done) begin
        seen_done = 1'b1; done_cyc = cyc;
      end else begin
        n_vec++;
        if (a_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: busy=%b required 1 at cycle %0d", a_busy, cyc); end
      end
    end
    #1;
    n_vec++;
    if (!seen_done) begin n_err++; $display("FAIL basic_done_timeout: done never rose, required 1"); end
    n_vec++;
    if (a_lc.size() != 10) begin n_err++; $display("FAIL basic_count: writes=%0d required 10", a_lc.size()); end
    for (int i = 0; i < a_lc.size() && i < e_core.size(); i++) begin
      n_vec++;
      if (a_lc[i] !== e_core[i] || a_la[i] !== e_addr[i] || a_ld[i] !== e_data[i] || a_lt[i] !== a_lt[0] + i) begin
        n_err++;
        $display("FAIL basic_write%0d: got (%0d,%h,%h,+%0d) required (%0d,%h,%h,+%0d)", i,
                 a_lc[i], a_la[i], a_ld[i], a_lt[i] - a_lt[0], e_core[i], e_addr[i], e_data[i], i);
      end
    end
    if (a_lt.size() == 10) begin
      n_vec++;
      if (done_cyc !== a_lt[9] + 1) begin n_err++; $display("FAIL basic_done_latency: done at +%0d required +1", done_cyc - a_lt[9]); end
    end
    n_vec++;
    if ({a_v, a_busy, a_err} !== 3'b000) begin n_err++; $display("FAIL basic_done_outs: v/busy/err=%b required 000", {a_v, a_busy, a_err}); end
    repeat (3) @(negedge clk);
    n_vec++;
    if (a_done !== 1'b1) begin n_err++; $display("FAIL basic_done_hold: done=%b required 1", a_done); end
  endtask

  task automatic test_backpressure();
    bit seen_done = 1'b0;
    bit stall_prev = 1'b0;
    logic [0:0]  s_core;
    logic [15:0] s_addr;
    logic [63:0] s_data;
    clear_logs();
    load_exp(2, 1'b1, 64'h8000_0000);
    a_ready = 1'b0;
    start_pass_a(1'b1, 39'h80000000);
    for (int t = 0; t < 400 && !seen_done; t++) begin
      @(negedge clk);
      if (a_done) begin
        seen_done = 1'b1;
      end else begin
        if (stall_prev) begin
          n_vec++;
          if (a_v !== 1'b1 || a_core !== s_core || a_addr !== s_addr || a_data !== s_data) begin
            n_err++;
            $display("FAIL bp_stable: got (%b,%0d,%h,%h) required (1,%0d,%h,%h)", a_v, a_core, a_addr, a_data, s_core, s_addr, s_data);
          end
        end
        stall_prev = a_v && !a_ready;
        s_core = a_core; s_addr = a_addr; s_data = a_data;
        @(posedge clk); #1;
        a_ready = ($urandom_range(0, 9) < 3);
      end
    end
    a_ready = 1'b1;
    #1;
    n_vec++;
    if (!seen_done) begin n_err++; $display("FAIL bp_done_timeout: done never rose, required 1"); end
    n_vec++;
    if (a_lc.size() != 10) begin n_err++; $display("FAIL bp_count: writes=%0d required 10", a_lc.size()); end
    for (int i = 0; i < a_lc.size() && i < e_core.size(); i++) begin
      n_vec++;
      if (a_lc[i] !== e_core[i] || a_la[i] !== e_addr[i] || a_ld[i] !== e_data[i]) begin
        n_err++;
        $display("FAIL bp_write%0d: got (%0d,%h,%h) required (%0d,%h,%h)", i, a_lc[i], a_la[i], a_ld[i], e_core[i], e_addr[i], e_data[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    bit seen_done = 1'b0;
    bit pulsed = 1'b0;
    clear_logs();
    load_exp(2, 1'b0, 64'h12_3456_789A);
    a_ready = 1'b1;
    start_pass_a(1'b0, 39'h12_3456_789A);
    for (int t = 0; t < 50 && !seen_done; t++) begin
      @(negedge clk);
      if (a_done) begin
        seen_done = 1'b1;
      end else if (a_v && a_addr == 16'h0008 && !pulsed) begin
        a_start = 1'b1; a_pc = 39'h7F_0000_0001; a_mode = 1'b1; pulsed = 1'b1;
      end else begin
        a_start = 1'b0;
      end
    end
    a_start = 1'b0;
    #1;
    n_vec++;
    if (!pulsed || !seen_done) begin n_err++; $display("FAIL ign_progress: pulsed=%b done=%b required 1 1", pulsed, seen_done); end
    n_vec++;
    if (a_lc.size() != 10) begin n_err++; $display("FAIL ign_count: writes=%0d required 10", a_lc.size()); end
    for (int i = 0; i < a_lc.size() && i < e_core.size(); i++) begin
      n_vec++;
      if (a_lc[i] !== e_core[i] || a_la[i] !== e_addr[i] || a_ld[i] !== e_data[i]) begin
        n_err++;
        $display("FAIL ign_write%0d: got (%0d,%h,%h) required (%0d,%h,%h)", i, a_lc[i], a_la[i], a_ld[i], e_core[i], e_addr[i], e_data[i]);
      end
    end
  endtask

  task automatic test_reset_midpass();
    bit found = 1'b0;
    bit seen_done = 1'b0;
    a_ready = 1'b1;
    start_pass_a(1'b1, 39'h80000000);
    for (int t = 0; t < 30 && !found; t++) begin
      @(negedge clk);
      if (a_v && a_addr == 16'h000C && a_core == 1'b1) found = 1'b1;
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL rst_reach_npc1: NPC write for core 1 not seen, required seen"); end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({a_v, a_busy, a_done, a_core, a_addr, a_data} !== '0) begin
      n_err++; $display("FAIL rst_async: outputs=%h required 0", {a_v, a_busy, a_done, a_core, a_addr, a_data});
    end
    @(negedge clk); rst = 1'b0;
    clear_logs();
    load_exp(2, 1'b1, 64'h8000_0000);
    start_pass_a(1'b1, 39'h80000000);
    for (int t = 0; t < 50 && !seen_done; t++) begin
      @(negedge clk);
      if (a_done) seen_done = 1'b1;
    end
    #1;
    n_vec++;
    if (a_lc.size() != 10) begin n_err++; $display("FAIL rst_restart_count: writes=%0d required 10", a_lc.size()); end
    for (int i = 0; i < a_lc.size() && i < e_core.size(); i++) begin
      n_vec++;
      if (a_lc[i] !== e_core[i] || a_la[i] !== e_addr[i] || a_ld[i] !== e_data[i]) begin
        n_err++;
        $display("FAIL rst_write%0d: got (%0d,%h,%h) required (%0d,%h,%h)", i, a_lc[i], a_la[i], a_ld[i], e_core[i], e_addr[i], e_data[i]);
      end
    end
  endtask

  task automatic test_three_cores();
    bit seen_done = 1'b0;
    clear_logs();
    load_exp(3, 1'b1, 64'h40);
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b1; b_mode = 1'b1; b_pc = 39'h40;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int t = 0; t < 100 && !seen_done; t++) begin
      @(negedge clk);
      if (b_done) begin
        seen_done = 1'b1;
      end else begin
        n_vec++;
        if (b_v && b_core > 2'd2) begin n_err++; $display("FAIL three_core_range: core=%0d required <=2", b_core); end
        @(posedge clk); #1;
        b_ready = ((cyc % 4) != 3);
      end
    end
    b_ready = 1'b1;
    #1;
    n_vec++;
    if (b_lc.size() != 15) begin n_err++; $display("FAIL three_count: writes=%0d required 15", b_lc.size()); end
    for (int i = 0; i < b_lc.size() && i < e_core.size(); i++) begin
      n_vec++;
      if (b_lc[i] !== e_core[i] || b_la[i] !== e_addr[i] || b_ld[i] !== e_data[i]) begin
        n_err++;
        $display("FAIL three_write%0d: got (%0d,%h,%h) required (%0d,%h,%h)", i, b_lc[i], b_la[i], b_ld[i], e_core[i], e_addr[i], e_data[i]);
      end
    end
    n_vec++;
    if ({b_done, b_busy, b_err} !== 3'b100) begin n_err++; $display("FAIL three_done: done/busy/err=%b required 100", {b_done, b_busy, b_err}); end
  endtask

`ifdef BP_CFG_SEQUENCER_TIMEOUT_EN
  task automatic test_timeout();
    bit seen_err = 1'b0;
    bit seen_done = 1'b0;
    int vcnt = 0;
    clear_logs();
    load_exp(2, 1'b1, 64'h8000_0000);
    a_ready = 1'b0;
    start_pass_a(1'b1, 39'h80000000);
    for (int t = 0; t < 40 && !seen_err; t++) begin
      @(negedge clk);
      if (a_err) seen_err = 1'b1;
      else if (a_v) vcnt++;
    end
    n_vec++;
    if (!seen_err || vcnt != 8) begin n_err++; $display("FAIL to_stall_cycles: err=%b after %0d stalled cycles required 1 after 8", seen_err, vcnt); end
    n_vec++;
    if ({a_v, a_busy} !== 2'b00) begin n_err++; $display("FAIL to_outs: v/busy=%b required 00", {a_v, a_busy}); end
    repeat (2) @(negedge clk);
    n_vec++;
    if (a_err !== 1'b1) begin n_err++; $display("FAIL to_hold: err=%b required 1", a_err); end
    a_ready = 1'b1;
    start_pass_a(1'b1, 39'h80000000);
    @(negedge clk);
    n_vec++;
    if ({a_err, a_v} !== 2'b01) begin n_err++; $display("FAIL to_clear: err/v=%b required 01", {a_err, a_v}); end
    for (int t = 0; t < 50 && !seen_done; t++) begin
      @(negedge clk);
      if (a_done) seen_done = 1'b1;
    end
    #1;
    n_vec++;
    if (a_lc.size() != 10) begin n_err++; $display("FAIL to_recover_count: writes=%0d required 10", a_lc.size()); end
    for (int i = 0; i < a_lc.size() && i < e_core.size(); i++) begin
      n_vec++;
      if (a_lc[i] !== e_core[i] || a_la[i] !== e_addr[i] || a_ld[i] !== e_data[i]) begin
        n_err++;
        $display("FAIL to_write%0d: got (%0d,%h,%h) required (%0d,%h,%h)", i, a_lc[i], a_la[i], a_ld[i], e_core[i], e_addr[i], e_data[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_reset_midpass();
    test_three_cores();
`ifdef BP_CFG_SEQUENCER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
